// File: rtl/fu_pkg.sv
// Shared types and default sizing for the functional-unit issue/writeback bridge.
package fu_pkg;

    localparam int INST_ID_BITS_D = 6;
    localparam int PRN_BITS_D     = 6;
    localparam int MAX_OPERANDS_D = 3;
    localparam int MAX_INFLIGHT_D = 4;
    localparam int DATA_W         = 64;

    typedef struct packed {
        logic [INST_ID_BITS_D-1:0]                   inst_id;
        logic [MAX_OPERANDS_D-1:0][PRN_BITS_D-1:0]   prn;
        logic [MAX_OPERANDS_D-1:0][DATA_W-1:0]       data;
        logic [MAX_OPERANDS_D-1:0]                   data_valid;
    } wb_entry_t;

endpackage

// File: rtl/fu_wb_fifo.sv
// Writeback FIFO: pointer + level counter; head reads as zero while empty so
// the writeback port is all-zero whenever nothing is presented (including reset).
module fu_wb_fifo
    import fu_pkg::*;
#(
    parameter int  DEPTH   = MAX_INFLIGHT_D,
    parameter type entry_t = wb_entry_t
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  entry_t din,
    input  logic   pop,
    output entry_t head,
    output logic   empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH + 1);

    entry_t          mem [DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [LW-1:0]   level;
    logic            full;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty = (level == '0);
    assign full  = (level == LW'(DEPTH));
    assign head  = empty ? '0 : mem[rd_ptr];

    // Push at full is only legal alongside a pop; the head slot is read before it is rewritten.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    a_no_overflow:  assert property (@(posedge clk) disable iff (!rst) !(push && full && !pop));
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst) !(pop && empty));

endmodule

// File: rtl/fu_issue_bridge.sv
// Issue side drives single-cycle FU pulses; FU result pulses land in a credit-bounded
// writeback FIFO tagged with the destination PRNs remembered at issue time.
module fu_issue_bridge
    import fu_pkg::*;
#(
    parameter int INST_ID_BITS = INST_ID_BITS_D,
    parameter int PRN_BITS     = PRN_BITS_D,
    parameter int MAX_OPERANDS = MAX_OPERANDS_D,
    parameter int MAX_INFLIGHT = MAX_INFLIGHT_D
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    iss_valid,
    output logic                                    iss_ready,
    input  logic [INST_ID_BITS-1:0]                 iss_inst_id,
    input  logic [31:0]                             iss_inst,
    input  logic [MAX_OPERANDS-1:0][DATA_W-1:0]     iss_op,
    input  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]   iss_out_prn,
    input  logic [63:0]                             iss_pc,
    output logic [INST_ID_BITS-1:0]                 fu_inst_id,
    output logic [31:0]                             fu_inst,
    output logic [MAX_OPERANDS-1:0][DATA_W-1:0]     fu_op,
    output logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]   fu_out_prn,
    output logic [63:0]                             fu_pc,
    output logic                                    fu_inst_valid,
    input  logic [INST_ID_BITS-1:0]                 fu_out_inst_id,
    input  logic [MAX_OPERANDS-1:0][DATA_W-1:0]     fu_out_data,
    input  logic [MAX_OPERANDS-1:0]                 fu_out_data_valid,
    input  logic                                    fu_out_valid,
    output logic                                    wb_valid,
    input  logic                                    wb_ready,
    output logic [INST_ID_BITS-1:0]                 wb_inst_id,
    output logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]   wb_prn,
    output logic [MAX_OPERANDS-1:0][DATA_W-1:0]     wb_data,
    output logic [MAX_OPERANDS-1:0]                 wb_data_valid
);

    localparam int CW     = $clog2(MAX_INFLIGHT + 1);
    localparam int NUM_ID = 2 ** INST_ID_BITS;

    typedef struct packed {
        logic [INST_ID_BITS-1:0]                 inst_id;
        logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]   prn;
        logic [MAX_OPERANDS-1:0][DATA_W-1:0]     data;
        logic [MAX_OPERANDS-1:0]                 data_valid;
    } entry_t;

    logic [CW-1:0]                          count;
    logic                                   iss_accept, wb_pop, fifo_empty;
    logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]  prn_tbl [NUM_ID];
    logic [NUM_ID-1:0]                      inflight;
    entry_t                                 push_entry, head;

    // Ready is purely state-derived so upstream never sees a loop through iss_valid.
    assign iss_ready  = rst && (count < CW'(MAX_INFLIGHT));
    assign iss_accept = iss_valid && iss_ready;
    assign wb_valid   = !fifo_empty;
    assign wb_pop     = wb_valid && wb_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (iss_accept && !wb_pop) begin
            count <= count + 1'b1;
        end else if (!iss_accept && wb_pop) begin
            count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fu_inst_valid <= 1'b0;
            fu_inst_id    <= '0;
            fu_inst       <= '0;
            fu_op         <= '0;
            fu_out_prn    <= '0;
            fu_pc         <= '0;
        end else begin
            fu_inst_valid <= iss_accept;
            if (iss_accept) begin
                fu_inst_id <= iss_inst_id;
                fu_inst    <= iss_inst;
                fu_op      <= iss_op;
                fu_out_prn <= iss_out_prn;
                fu_pc      <= iss_pc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (iss_accept) prn_tbl[iss_inst_id] <= iss_out_prn;
    end

    assign push_entry.inst_id    = fu_out_inst_id;
    assign push_entry.prn        = prn_tbl[fu_out_inst_id];
    assign push_entry.data       = fu_out_data;
    assign push_entry.data_valid = fu_out_data_valid;

    fu_wb_fifo #(
        .DEPTH   (MAX_INFLIGHT),
        .entry_t (entry_t)
    ) u_wb_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fu_out_valid),
        .din   (push_entry),
        .pop   (wb_pop),
        .head  (head),
        .empty (fifo_empty)
    );

    assign wb_inst_id    = head.inst_id;
    assign wb_prn        = head.prn;
    assign wb_data       = head.data;
    assign wb_data_valid = head.data_valid;

    // An ID stays live from issue until its writeback leaves; reuse before then would alias the PRN table.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight <= '0;
        end else begin
            if (wb_pop)     inflight[wb_inst_id]  <= 1'b0;
            if (iss_accept) inflight[iss_inst_id] <= 1'b1;
        end
    end

    a_unique_id: assert property (@(posedge clk) disable iff (!rst)
        iss_accept |-> (!inflight[iss_inst_id] || (wb_pop && wb_inst_id == iss_inst_id)));

endmodule

// File: tb/tb_fu_issue_bridge.sv
// Directed and randomized checks of fu_issue_bridge against a queue-based reference model.
module tb_fu_issue_bridge;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic                  iss_valid = 1'b0;
    logic                  iss_ready;
    logic [5:0]            iss_inst_id = '0;
    logic [31:0]           iss_inst = '0;
    logic [2:0][63:0]      iss_op = '0;
    logic [2:0][5:0]       iss_out_prn = '0;
    logic [63:0]           iss_pc = '0;
    logic [5:0]            fu_inst_id;
    logic [31:0]           fu_inst;
    logic [2:0][63:0]      fu_op;
    logic [2:0][5:0]       fu_out_prn;
    logic [63:0]           fu_pc;
    logic                  fu_inst_valid;
    logic [5:0]            fu_out_inst_id = '0;
    logic [2:0][63:0]      fu_out_data = '0;
    logic [2:0]            fu_out_data_valid = '0;
    logic                  fu_out_valid = 1'b0;
    logic                  wb_valid;
    logic                  wb_ready = 1'b0;
    logic [5:0]            wb_inst_id;
    logic [2:0][5:0]       wb_prn;
    logic [2:0][63:0]      wb_data;
    logic [2:0]            wb_data_valid;

    fu_issue_bridge dut (
        .clk(clk), .rst(rst),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_inst_id(iss_inst_id),
        .iss_inst(iss_inst), .iss_op(iss_op), .iss_out_prn(iss_out_prn), .iss_pc(iss_pc),
        .fu_inst_id(fu_inst_id), .fu_inst(fu_inst), .fu_op(fu_op), .fu_out_prn(fu_out_prn),
        .fu_pc(fu_pc), .fu_inst_valid(fu_inst_valid),
        .fu_out_inst_id(fu_out_inst_id), .fu_out_data(fu_out_data),
        .fu_out_data_valid(fu_out_data_valid), .fu_out_valid(fu_out_valid),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_inst_id(wb_inst_id),
        .wb_prn(wb_prn), .wb_data(wb_data), .wb_data_valid(wb_data_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]       id;
        logic [2:0][5:0]  prn;
        logic [2:0][63:0] data;
        logic [2:0]       dv;
    } ent_t;

    // Reference model: outstanding credits, completion-ordered writeback queue, id->prn map.
    int               vectors = 0;
    int               miscompares = 0;
    int               m_count = 0;
    ent_t             wbq[$];
    logic [2:0][5:0]  prn_map [64];
    bit               m_inflight [64];
    bit               m_fu_vld = 1'b0;
    int               pend[$];
    logic [5:0]       last_id = '0;
    logic [31:0]      last_inst = '0;
    logic [2:0][63:0] last_op = '0;
    logic [2:0][5:0]  last_prn = '0;
    logic [63:0]      last_pc = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        bit   acc, pop;
        ent_t e;
        check("iss_ready", 64'(iss_ready), 64'(m_count < 4));
        check("wb_valid", 64'(wb_valid), 64'(wbq.size() != 0));
        if (wbq.size() != 0) begin
            check("wb_inst_id", 64'(wb_inst_id), 64'(wbq[0].id));
            check("wb_data_valid", 64'(wb_data_valid), 64'(wbq[0].dv));
            for (int i = 0; i < 3; i++) begin
                check("wb_prn", 64'(wb_prn[i]), 64'(wbq[0].prn[i]));
                check("wb_data", wb_data[i], wbq[0].data[i]);
            end
        end
        check("fu_inst_valid", 64'(fu_inst_valid), 64'(m_fu_vld));
        check("fu_inst_id", 64'(fu_inst_id), 64'(last_id));
        check("fu_inst", 64'(fu_inst), 64'(last_inst));
        check("fu_pc", fu_pc, last_pc);
        for (int i = 0; i < 3; i++) begin
            check("fu_op", fu_op[i], last_op[i]);
            check("fu_out_prn", 64'(fu_out_prn[i]), 64'(last_prn[i]));
        end
        acc = iss_valid && (m_count < 4);
        pop = wb_ready && (wbq.size() != 0);
        if (acc) begin
            prn_map[iss_inst_id]    = iss_out_prn;
            m_inflight[iss_inst_id] = 1'b1;
            pend.push_back(int'(iss_inst_id));
            last_id = iss_inst_id; last_inst = iss_inst; last_op = iss_op;
            last_prn = iss_out_prn; last_pc = iss_pc;
        end
        m_fu_vld = acc;
        if (pop) begin
            e = wbq.pop_front();
            m_inflight[e.id] = 1'b0;
        end
        if (fu_out_valid) begin
            e.id = fu_out_inst_id; e.prn = prn_map[fu_out_inst_id];
            e.data = fu_out_data; e.dv = fu_out_data_valid;
            wbq.push_back(e);
        end
        m_count = m_count + int'(acc) - int'(pop);
        @(posedge clk);
        #1;
        iss_valid    = 1'b0;
        fu_out_valid = 1'b0;
    endtask

    task automatic set_issue(input logic [5:0] id, input logic [2:0][5:0] prn);
        iss_valid   = 1'b1;
        iss_inst_id = id;
        iss_out_prn = prn;
        iss_inst    = $urandom;
        iss_pc      = {$urandom, $urandom};
        for (int i = 0; i < 3; i++) iss_op[i] = {$urandom, $urandom};
    endtask

    task automatic set_ret(input logic [5:0] id, input logic [63:0] d0, input logic [2:0] dv);
        fu_out_valid      = 1'b1;
        fu_out_inst_id    = id;
        fu_out_data[0]    = d0;
        fu_out_data[1]    = {$urandom, $urandom};
        fu_out_data[2]    = {$urandom, $urandom};
        fu_out_data_valid = dv;
    endtask

    task automatic drain();
        wb_ready = 1'b1;
        for (int n = 0; n < 16 && wbq.size() != 0; n++) tick();
        wb_ready = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_iss_ready"}, 64'(iss_ready), 64'd0);
        check({tag, "_wb_valid"}, 64'(wb_valid), 64'd0);
        check({tag, "_fu_vld"}, 64'(fu_inst_valid), 64'd0);
        check({tag, "_fu_id"}, 64'(fu_inst_id), 64'd0);
        check({tag, "_fu_inst"}, 64'(fu_inst), 64'd0);
        check({tag, "_fu_pc"}, fu_pc, 64'd0);
        check({tag, "_fu_op"}, fu_op[0], 64'd0);
        check({tag, "_fu_prn"}, 64'(fu_out_prn), 64'd0);
        check({tag, "_wb_id"}, 64'(wb_inst_id), 64'd0);
        check({tag, "_wb_prn"}, 64'(wb_prn), 64'd0);
        check({tag, "_wb_data"}, wb_data[0], 64'd0);
        check({tag, "_wb_dv"}, 64'(wb_data_valid), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [5:0] rid;
        int         k;

        // Power-on reset
        #3;
        check_all_zero("por");
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("por_ready", 64'(iss_ready), 64'd1);

        // Single round trip
        set_issue(6'd5, 18'd7);
        tick();
        check("rt_vld_hi", 64'(fu_inst_valid), 64'd1);
        check("rt_fu_id", 64'(fu_inst_id), 64'd5);
        set_ret(6'd5, 64'hDEAD, 3'b001);
        tick();
        check("rt_vld_lo", 64'(fu_inst_valid), 64'd0);
        check("rt_wb_valid", 64'(wb_valid), 64'd1);
        check("rt_wb_id", 64'(wb_inst_id), 64'd5);
        check("rt_wb_prn0", 64'(wb_prn[0]), 64'd7);
        check("rt_wb_data0", wb_data[0], 64'hDEAD);
        drain();

        // Credit exhaustion
        for (int i = 1; i <= 4; i++) begin
            set_issue(6'(i), 18'(i + 40));
            tick();
        end
        check("ce_ready0", 64'(iss_ready), 64'd0);
        for (int i = 1; i <= 4; i++) begin
            set_ret(6'(i), 64'(i * 100), 3'b111);
            tick();
        end
        check("ce_still0", 64'(iss_ready), 64'd0);
        wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;
        check("ce_ready1", 64'(iss_ready), 64'd1);
        drain();

        // Out-of-order completion
        set_issue(6'd1, 18'd10); tick();
        set_issue(6'd2, 18'd20); tick();
        set_ret(6'd2, 64'h2222, 3'b001); tick();
        set_ret(6'd1, 64'h1111, 3'b001); tick();
        check("ooo_first_id", 64'(wb_inst_id), 64'd2);
        check("ooo_first_prn", 64'(wb_prn[0]), 64'd20);
        wb_ready = 1'b1;
        tick();
        check("ooo_second_id", 64'(wb_inst_id), 64'd1);
        check("ooo_second_prn", 64'(wb_prn[0]), 64'd10);
        tick();
        wb_ready = 1'b0;

        // Issue and writeback in the same cycle at count 3
        set_issue(6'd10, 18'd3); tick();
        set_issue(6'd11, 18'd4); tick();
        set_issue(6'd12, 18'd5); tick();
        set_ret(6'd10, 64'hA0, 3'b001); tick();
        set_issue(6'd13, 18'd6);
        wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;
        check("sim_ready", 64'(iss_ready), 64'd1);
        set_issue(6'd14, 18'd8); tick();
        check("sim_full", 64'(iss_ready), 64'd0);
        for (int i = 11; i <= 14; i++) begin
            set_ret(6'(i), 64'(i), 3'b010);
            tick();
        end
        drain();

        // Push and pop together with one entry held
        set_issue(6'd20, 18'd21); tick();
        set_issue(6'd21, 18'd22); tick();
        set_ret(6'd20, 64'h20, 3'b001); tick();
        set_ret(6'd21, 64'h21, 3'b001);
        wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;
        check("pp_valid", 64'(wb_valid), 64'd1);
        check("pp_head", 64'(wb_inst_id), 64'd21);
        check("pp_prn", 64'(wb_prn[0]), 64'd22);
        drain();

        // Randomized traffic
        pend.delete();
        for (int c = 0; c < 500; c++) begin
            if ($urandom_range(0, 9) < 6) begin
                do rid = 6'($urandom_range(0, 63)); while (m_inflight[rid]);
                set_issue(rid, 18'($urandom));
            end
            if (pend.size() != 0 && $urandom_range(0, 1) == 1) begin
                k = int'($urandom_range(0, pend.size() - 1));
                set_ret(6'(pend[k]), {$urandom, $urandom}, 3'($urandom));
                pend.delete(k);
            end
            wb_ready = ($urandom_range(0, 9) < 6);
            tick();
        end
        wb_ready = 1'b0;
        while (pend.size() != 0) begin
            set_ret(6'(pend.pop_front()), {$urandom, $urandom}, 3'($urandom));
            tick();
        end
        drain();

        // Reset mid-operation with count 3, FIFO level 2
        set_issue(6'd30, 18'd1); tick();
        set_issue(6'd31, 18'd2); tick();
        set_issue(6'd32, 18'd3); tick();
        set_ret(6'd30, 64'h30, 3'b001); tick();
        set_ret(6'd31, 64'h31, 3'b001); tick();
        check("mr_pre_valid", 64'(wb_valid), 64'd1);
        check("mr_pre_fu_id", 64'(fu_inst_id), 64'd32);
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("mr");
        m_count = 0; wbq.delete(); pend.delete(); m_fu_vld = 1'b0;
        for (int i = 0; i < 64; i++) m_inflight[i] = 1'b0;
        last_id = '0; last_inst = '0; last_op = '0; last_prn = '0; last_pc = '0;
        #2;
        rst = 1'b1;
        @(posedge clk); #1;
        check("mr_post_ready", 64'(iss_ready), 64'd1);
        check("mr_post_wb_valid", 64'(wb_valid), 64'd0);
        set_issue(6'd40, 18'd9); tick();
        set_ret(6'd40, 64'hBEEF, 3'b100); tick();
        check("mr_rt_prn", 64'(wb_prn[0]), 64'd9);
        drain();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fu_issue_bridge.md
# fu_issue_bridge

Controller-side endpoint of the functional-unit protocol. It accepts issued instructions from a reservation station over a valid/ready handshake and drives them into one FU as single-cycle `inst_valid` pulses. It captures the FU's unthrottled result pulses into a writeback FIFO and presents them to the writeback/CDB arbiter over valid/ready. A credit counter bounds in-flight work so the FIFO never overflows, since the FU cannot be stalled.

## Interface
Clock is `clk`. Reset is `rst`: asynchronous, active-low.

Parameters:
- `INST_ID_BITS`, 6, instruction ID width
- `PRN_BITS`, 6, physical register number width
- `MAX_OPERANDS`, 3, operand / output slots
- `MAX_INFLIGHT`, 4, credits; also the writeback FIFO depth

Ports:
- `clk` in 1: clock
- `rst` in 1: async active-low reset
- `iss_valid` in 1: issue request
- `iss_ready` out 1: bridge can accept an issue
- `iss_inst_id` in INST_ID_BITS: instruction ID
- `iss_inst` in 32: instruction word
- `iss_op` in 64 x MAX_OPERANDS: source operands
- `iss_out_prn` in PRN_BITS x MAX_OPERANDS: destination PRNs
- `iss_pc` in 64: program counter
- `fu_inst_id`, `fu_inst`, `fu_op`, `fu_out_prn`, `fu_pc` out (same widths): registered FU inputs
- `fu_inst_valid` out 1: FU input valid, one-cycle pulse
- `fu_out_inst_id` in INST_ID_BITS: completing instruction ID
- `fu_out_data` in 64 x MAX_OPERANDS: FU results
- `fu_out_data_valid` in 1 x MAX_OPERANDS: per-slot result valid
- `fu_out_valid` in 1: FU result pulse
- `wb_valid` out 1: writeback entry available
- `wb_ready` in 1: writeback consumer accepts
- `wb_inst_id` out INST_ID_BITS: ID of the head entry
- `wb_prn` out PRN_BITS x MAX_OPERANDS: destination PRNs of the head entry
- `wb_data` out 64 x MAX_OPERANDS: result data of the head entry
- `wb_data_valid` out 1 x MAX_OPERANDS: per-slot valid of the head entry

## Operation
- **Issue accept:** occurs on `iss_valid && iss_ready`. That edge does three things:
  - registers all `iss_*` fields into the `fu_*` outputs;
  - sets `fu_inst_valid` for exactly the next cycle;
  - writes `iss_out_prn` into the PRN table at index `iss_inst_id`.
- **`fu_*` fields:** hold their last value when `fu_inst_valid` is low.
- **PRN table:** 2^INST_ID_BITS entries of `MAX_OPERANDS` x PRN_BITS. Upstream guarantees in-flight IDs are unique. A repeated in-flight ID is a protocol violation and is caught by an assertion.
- **Credit count:** width `$clog2(MAX_INFLIGHT+1)`.
  - +1 on issue accept, −1 on writeback handshake `wb_valid && wb_ready`.
  - Both events in the same cycle leave the count unchanged.
  - `iss_ready = rst && (count < MAX_INFLIGHT)`. It depends only on state, with no combinational path from `iss_valid`.
- **Result capture:** `fu_out_valid` pushes one FIFO entry containing:
  - `fu_out_inst_id`, `fu_out_data` and `fu_out_data_valid`;
  - the PRN table entry looked up at `fu_out_inst_id`.
- **Completion order:** the FU may complete out of order. The FIFO preserves FU completion order, not issue order.
- **Writeback port:** `wb_*` show the FIFO head. `wb_valid` = FIFO non-empty. A handshake pops the head.
- **Overflow check:** a push into a full FIFO cannot occur while credits are respected; an assertion flags it. An empty-FIFO pop cannot occur because `wb_valid` is low.
- **Simultaneous push and pop:** legal at any level, including full (pop frees the slot) and a level of 1. The level is unchanged and order is preserved.
- **Reset (also mid-operation, asynchronous):**
  - credit count and FIFO pointers/level go to 0;
  - `fu_inst_valid`, `wb_valid`, `iss_ready` go to 0;
  - all `fu_*` and `wb_*` data outputs go to 0;
  - PRN table contents are don't-care.
  - In-flight FU results arriving after reset release are undefined; the system resets the FU together with the bridge.

## Timing
- **Issue to FU:** accept at edge N → `fu_inst_valid` high during cycle N+1 only. Back-to-back issues give consecutive pulses.
- **FU result to writeback:** `fu_out_valid` at edge M → `wb_valid` high from cycle M+1 at the earliest. There is no same-cycle bypass.
- **Credit return:** a writeback handshake at edge K → `iss_ready` high from cycle K+1, if it was throttled.
- **Throughput:** 1 issue and 1 writeback per cycle, sustained.

## Structure
- **Shared package `fu_pkg`:**
  - `wb_entry_t` struct holding `inst_id`, `prn[MAX_OPERANDS]`, `data[MAX_OPERANDS]`, `data_valid[MAX_OPERANDS]`;
  - default parameter constants.
- **Sub-module `fu_wb_fifo`:** parameterised depth-`MAX_INFLIGHT` synchronous FIFO of `wb_entry_t`, using pointers plus a level counter, with async active-low reset.
- **Top level:** holds the credit counter, the PRN table and the `fu_*` output registers.

## Test plan
- **Reset mid-operation:** count=3 and FIFO level=2, drive `rst` low asynchronously → all outputs 0 immediately. After release, `iss_ready`=1 and `wb_valid`=0.
- **Single round trip:** issue id=5, prn={7,0,0}.
  - `fu_inst_valid` is high exactly one cycle with `fu_inst_id`=5.
  - FU returns id=5, data[0]=0xDEAD, valid={1,0,0} → next cycle `wb_valid`=1, `wb_inst_id`=5, `wb_prn[0]`=7, `wb_data[0]`=0xDEAD.
- **Credit exhaustion:** hold `wb_ready`=0 and issue ids 1–4 with matching FU results → `iss_ready`=0 after the 4th accept. One `wb_ready` pulse → `iss_ready`=1 the following cycle.
- **Out-of-order completion:** issue id=1 (prn 10), then id=2 (prn 20); FU returns 2, then 1 → writeback order is id 2/prn 20, then id 1/prn 10.
- **Simultaneous events at count=3:** issue accept together with a writeback handshake → count stays 3 and `iss_ready` stays 1.
- **Push and pop with one entry:** FIFO holds 1 entry; `fu_out_valid` and `wb_ready` in the same cycle → level stays 1 and the new entry becomes the head.
